vga_scan_controller: RTL

- Sequences the horizontal and vertical scan counters of the display path and generates the pixel-rate strobe.
- Decodes sync, blanking and active-video windows; outputs current pixel coordinates to the pixel generator.
- Sits between the system clock domain and the VGA output pins.
- Single clock domain; all timing is set by parameters.

---
 rtl/vga_scan_controller.sv | 101 ++++++++++
 1 files changed

// File: rtl/vga_scan_controller.sv
// VGA scan controller: pixel-rate divider, nested x/y scan counters and
// registered sync / blanking / start-of-line / start-of-frame decode.
module vga_scan_controller #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned DIV      = 4,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pixel_tick,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int unsigned DW         = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [HW-1:0] x_d;
  logic [VW-1:0] y_d;
  logic          wrap_c;
  logic          hsync_d;
  logic          vsync_d;
  logic          video_on_d;
  logic          line_start_d;
  logic          frame_start_d;

  // Next-state of divider and scan counters; counters only move on divider wrap.
  always_comb begin
    wrap_c = enable && (div_q == DW'(DIV - 1));
    div_d  = div_q;
    x_d    = x;
    y_d    = y;
    if (enable) begin
      div_d = wrap_c ? '0 : div_q + DW'(1);
    end
    if (wrap_c) begin
      if (x == HW'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y == VW'(V_TOTAL - 1)) ? '0 : y + VW'(1);
      end else begin
        x_d = x + HW'(1);
      end
    end
  end

  // Window decode from next-state counters so registered flags line up with x/y.
  always_comb begin
    hsync_d       = !((x_d >= HW'(H_SYNC_BEG)) && (x_d <= HW'(H_SYNC_END)));
    vsync_d       = !((y_d >= VW'(V_SYNC_BEG)) && (y_d <= VW'(V_SYNC_END)));
    video_on_d    = (x_d < HW'(H_ACTIVE)) && (y_d < VW'(V_ACTIVE));
    line_start_d  = wrap_c && (x_d == '0);
    frame_start_d = wrap_c && (x_d == '0) && (y_d == '0);
  end

  // State and output registers; held values come through the next-state logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      x           <= '0;
      y           <= '0;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b1;
    end else begin
      div_q       <= div_d;
      x           <= x_d;
      y           <= y_d;
      pixel_tick  <= wrap_c;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      video_on    <= video_on_d;
    end
  end

endmodule
